// File: rtl/fmap_pkg.sv
// Shared geometry, pixel type and FSM state type for the layer-1 padded feature-map stream.
package fmap_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CH        = 32;
  localparam int unsigned IN_ROWS   = 32;
  localparam int unsigned IN_COLS   = 24;
  localparam int unsigned PAD       = 1;
  localparam int unsigned OUT_ROWS  = IN_ROWS + 2 * PAD;
  localparam int unsigned OUT_COLS  = IN_COLS + 2 * PAD;
  localparam int unsigned OUT_BEATS = OUT_ROWS * OUT_COLS;

  typedef logic [DATA_W-1:0] pixel_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/raster_pos_counter.sv
// Row-major position counter over the padded raster; flags the last position and border positions.
module raster_pos_counter #(
  parameter int unsigned IN_ROWS = 32,
  parameter int unsigned IN_COLS = 24,
  parameter int unsigned PAD     = 1,
  localparam int unsigned ROWS   = IN_ROWS + 2 * PAD,
  localparam int unsigned COLS   = IN_COLS + 2 * PAD,
  localparam int unsigned RW     = $clog2(ROWS),
  localparam int unsigned CW     = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last_pos,
  output logic          is_border
);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LO   = RW'(PAD);
  localparam logic [RW-1:0] ROW_HI   = RW'(PAD + IN_ROWS);
  localparam logic [CW-1:0] COL_LO   = CW'(PAD);
  localparam logic [CW-1:0] COL_HI   = CW'(PAD + IN_COLS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_comb begin
    last_pos  = (row == ROW_LAST) && (col == COL_LAST);
    is_border = (row < ROW_LO) || (row >= ROW_HI) || (col < COL_LO) || (col >= COL_HI);
  end

endmodule

// File: rtl/fmap_pad_tx.sv
// Emits the zero-padded raster of one feature map, passing interior pixels from upstream with ready/valid.
module fmap_pad_tx #(
  parameter int unsigned DATA_W  = fmap_pkg::DATA_W,
  parameter int unsigned CH      = fmap_pkg::CH,
  parameter int unsigned IN_ROWS = fmap_pkg::IN_ROWS,
  parameter int unsigned IN_COLS = fmap_pkg::IN_COLS,
  parameter int unsigned PAD     = fmap_pkg::PAD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [CH*DATA_W-1:0] s_data,
  output logic                 valid_out,
  output logic [CH*DATA_W-1:0] data_out,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 busy
);

  import fmap_pkg::*;

  localparam int unsigned RW = $clog2(IN_ROWS + 2 * PAD);
  localparam int unsigned CW = $clog2(IN_COLS + 2 * PAD);

  tx_state_t     state, state_next;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          last_pos;
  logic          is_border;
  logic          adv;
  logic          clr;

  raster_pos_counter #(
    .IN_ROWS (IN_ROWS),
    .IN_COLS (IN_COLS),
    .PAD     (PAD)
  ) u_pos (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .en        (adv),
    .row       (row),
    .col       (col),
    .last_pos  (last_pos),
    .is_border (is_border)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (adv && last_pos) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Border beats never wait on upstream; interior beats stall the raster until s_valid.
  always_comb begin
    busy    = (state == RUN);
    clr     = (state == IDLE) && start;
    s_ready = (state == RUN) && !is_border;
    adv     = (state == RUN) && (is_border || s_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out   <= 1'b0;
      data_out    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      valid_out   <= adv;
      frame_start <= adv && (row == '0) && (col == '0);
      frame_done  <= adv && last_pos;
      if (adv) data_out <= is_border ? '0 : s_data;
    end
  end

endmodule
